// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared constants, FSM states and default pattern for the WS2812 frame feeder
package ws2812_pkg;

  localparam int COLOR_W = 24;

  localparam logic [COLOR_W-1:0] GRB_GREEN = 24'h100000;
  localparam logic [COLOR_W-1:0] GRB_RED   = 24'h001000;
  localparam logic [COLOR_W-1:0] GRB_BLUE  = 24'h000010;
  localparam logic [COLOR_W-1:0] GRB_OFF   = 24'h000000;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  // Pattern green, red, blue repeating; the remainder by 3 uses restoring division.
  function automatic logic [COLOR_W-1:0] default_color(input int i);
    int r;
    r = i;
    for (int s = 10; s >= 0; s--) begin
      if (r >= (3 << s)) r = r - (3 << s);
    end
    case (r)
      0:       return GRB_GREEN;
      1:       return GRB_RED;
      default: return GRB_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/ws2812_frame_timer.sv
// rtl/ws2812_frame_timer.sv - free-running frame period counter with a one-cycle tick
module ws2812_frame_timer #(
  parameter int FRAME_TICKS = 1_500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_count == CNT_W'(FRAME_TICKS - 1));
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ws2812_frame_feeder.sv
// rtl/ws2812_frame_feeder.sv - rotating GRB colour store streamed once per frame period
module ws2812_frame_feeder
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int FRAME_TICKS = 1_500_000,
  parameter int IDX_W       = $clog2(NUM_LEDS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_addr,
  input  logic [COLOR_W-1:0] i_wr_data,
  input  logic               i_rot_en,
  input  logic               i_rot_dir,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [COLOR_W-1:0] o_pix_data,
  output logic               o_pix_last,
  output logic               o_frame_overrun
);

  state_t r_state, w_state_next;

  logic [COLOR_W-1:0] r_store [NUM_LEDS];
  logic [IDX_W-1:0]   r_offset, r_frame_off, r_idx;
  logic [COLOR_W-1:0] r_pix_data;
  logic               r_pix_valid, r_pix_last, r_pending, r_overrun;

  logic               w_tick, w_consume, w_load, w_fire, w_at_last, w_wr_ok, w_next_last;
  logic [IDX_W-1:0]   w_offset_next, w_next_addr;
  logic [IDX_W:0]     w_sum, w_sum_wrap, w_idx_inc;

  ws2812_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  assign w_wr_ok   = i_wr_en && ({1'b0, i_wr_addr} < (IDX_W+1)'(NUM_LEDS));
  assign w_at_last = (r_idx == IDX_W'(NUM_LEDS - 1));

  // Address of the next pixel: idx+1+frame_off folded back into 0..NUM_LEDS-1.
  assign w_idx_inc   = {1'b0, r_idx} + (IDX_W+1)'(1);
  assign w_sum       = w_idx_inc + {1'b0, r_frame_off};
  assign w_sum_wrap  = (w_sum >= (IDX_W+1)'(NUM_LEDS)) ? w_sum - (IDX_W+1)'(NUM_LEDS) : w_sum;
  assign w_next_addr = IDX_W'(w_sum_wrap);
  assign w_next_last = (w_idx_inc == (IDX_W+1)'(NUM_LEDS - 1));

  always_comb begin
    w_offset_next = r_offset;
    if (i_rot_dir) begin
      w_offset_next = (r_offset == '0) ? IDX_W'(NUM_LEDS - 1) : r_offset - 1'b1;
    end else begin
      w_offset_next = (r_offset == IDX_W'(NUM_LEDS - 1)) ? '0 : r_offset + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_load       = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_consume    = 1'b1;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_load       = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        if (r_pix_valid && i_pix_ready) begin
          w_fire = 1'b1;
          if (w_at_last) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending   <= 1'b1;
      r_overrun   <= 1'b0;
      r_offset    <= '0;
      r_frame_off <= '0;
      r_idx       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_pix_data  <= GRB_OFF;
      for (int i = 0; i < NUM_LEDS; i++) r_store[i] <= default_color(i);
    end else begin
      // A tick landing on the consume cycle re-arms pending without counting as overrun.
      if (w_tick)         r_pending <= 1'b1;
      else if (w_consume) r_pending <= 1'b0;
      r_overrun <= w_tick && r_pending && !w_consume;

      if (w_tick && i_rot_en) r_offset <= w_offset_next;
      if (w_wr_ok)            r_store[i_wr_addr] <= i_wr_data;

      if (w_load) begin
        r_frame_off <= r_offset;
        r_idx       <= '0;
        r_pix_data  <= r_store[r_offset];
        r_pix_last  <= 1'b0;
        r_pix_valid <= 1'b1;
      end else if (w_fire) begin
        if (w_at_last) begin
          r_pix_valid <= 1'b0;
          r_pix_last  <= 1'b0;
        end else begin
          r_idx      <= r_idx + 1'b1;
          r_pix_data <= r_store[w_next_addr];
          r_pix_last <= w_next_last;
        end
      end
    end
  end

  assign o_pix_valid     = r_pix_valid;
  assign o_pix_data      = r_pix_data;
  assign o_pix_last      = r_pix_last;
  assign o_frame_overrun = r_overrun;

endmodule
